// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte sources.
// Round-robin selection with a message lock; the owner keeps the transmitter
// until it sends a byte flagged last, or until it idles for LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]           i_req_last,
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic [DATA_BITS-1:0]         o_tx_data,
    output logic                         o_tx_write,
    input  logic                         i_tx_busy,
    output logic [NUM_REQ-1:0]           o_grant,
    output logic                         o_locked,
    output logic                         o_err
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(LOCK_TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE_HOT_C = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     owner_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [NUM_REQ-1:0]   ready_r;
    logic                 locked_r;
    logic                 err_r;
    logic                 last_r;
    logic                 tx_write_r;
    logic [DATA_BITS-1:0] tx_data_r;
    logic [CNT_W-1:0]     idle_cnt_r;

    logic                 pick_found_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic [IDX_W-1:0]     cand_s;
    logic [IDX_W-1:0]     lane_s;
    logic [DATA_BITS-1:0] lane_data_a [NUM_REQ];
    logic [DATA_BITS-1:0] lane_data_s;
    logic                 owner_valid_s;
    logic                 owner_last_s;
    logic [CNT_W-1:0]     idle_next_s;

    // Round-robin search: first valid requester strictly after the pointer.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(ptr_r) + i) % NUM_REQ);
            if (!pick_found_s && i_req_valid[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Lane selection and per-owner views of the request inputs.
    always_comb begin
        for (int n = 0; n < NUM_REQ; n++) begin
            lane_data_a[n] = i_req_data[n*DATA_BITS +: DATA_BITS];
        end
        if (locked_r) begin
            lane_s = owner_r;
        end else begin
            lane_s = pick_idx_s;
        end
        lane_data_s   = lane_data_a[lane_s];
        owner_valid_s = i_req_valid[owner_r];
        owner_last_s  = i_req_last[owner_r];
        idle_next_s   = idle_cnt_r + CNT_W'(1);
    end

    // Arbitration FSM; grant, lock and transmitter strobes are all registered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= ARB;
            ptr_r      <= IDX_W'(NUM_REQ - 1);
            owner_r    <= '0;
            grant_r    <= '0;
            ready_r    <= '0;
            locked_r   <= 1'b0;
            err_r      <= 1'b0;
            last_r     <= 1'b0;
            tx_write_r <= 1'b0;
            tx_data_r  <= '0;
            idle_cnt_r <= '0;
        end else begin
            tx_write_r <= 1'b0;
            tx_data_r  <= '0;
            ready_r    <= '0;
            case (state_r)
                ARB: begin
                    // A frame may still be in flight (e.g. after reset): wait it out.
                    if (!i_tx_busy) begin
                        if (!locked_r) begin
                            if (pick_found_s) begin
                                owner_r    <= pick_idx_s;
                                grant_r    <= ONE_HOT_C << pick_idx_s;
                                locked_r   <= 1'b1;
                                idle_cnt_r <= '0;
                                tx_write_r <= 1'b1;
                                tx_data_r  <= lane_data_s;
                                ready_r    <= ONE_HOT_C << lane_s;
                                state_r    <= ISSUE;
                            end
                        end else if (owner_valid_s) begin
                            idle_cnt_r <= '0;
                            tx_write_r <= 1'b1;
                            tx_data_r  <= lane_data_s;
                            ready_r    <= ONE_HOT_C << lane_s;
                            state_r    <= ISSUE;
                        end else if (LOCK_TIMEOUT != 0) begin
                            if (idle_next_s == TIMEOUT_C) begin
                                locked_r   <= 1'b0;
                                grant_r    <= '0;
                                ptr_r      <= owner_r;
                                idle_cnt_r <= '0;
                            end else begin
                                idle_cnt_r <= idle_next_s;
                            end
                        end
                    end
                end
                ISSUE: begin
                    last_r  <= owner_last_s;
                    state_r <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state_r <= WAIT_DONE;
                    end else begin
                        // Transmitter ignored the write: flag it and move on.
                        err_r <= 1'b1;
                        if (last_r) begin
                            locked_r <= 1'b0;
                            grant_r  <= '0;
                            ptr_r    <= owner_r;
                        end
                        state_r <= ARB;
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (last_r) begin
                            locked_r <= 1'b0;
                            grant_r  <= '0;
                            ptr_r    <= owner_r;
                        end
                        state_r <= ARB;
                    end
                end
                default: begin
                    state_r <= ARB;
                end
            endcase
        end
    end

    assign o_req_ready = ready_r;
    assign o_tx_data   = tx_data_r;
    assign o_tx_write  = tx_write_r;
    assign o_grant     = grant_r;
    assign o_locked    = locked_r;
    assign o_err       = err_r;

endmodule
